// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - opcodes, immediate constant and FSM states for the shared ALU arbiter
package alu_ctrl_pkg;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_ADDK = 2'b10;
   localparam logic [1:0] OP_SUBK = 2'b11;

   localparam logic [7:0] CONST_K = 8'hAA;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic logic [1:0] idx_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu8_unit.sv
// rtl/alu8_unit.sv - combinational 8-bit add/sub ALU with carry/borrow flag
module alu8_unit
   import alu_ctrl_pkg::*;
#(
   parameter logic [7:0] K = 8'hAA
) (
   input  logic [1:0] op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] result,
   output logic       flag
);

   logic [8:0] wide;

   // 9-bit arithmetic: bit 8 is carry for adds, borrow for subtracts
   always_comb begin
      wide = 9'd0;
      case (op)
         OP_ADD:  wide = {1'b0, a} + {1'b0, b};
         OP_SUB:  wide = {1'b0, a} - {1'b0, b};
         OP_ADDK: wide = {1'b0, a} + {1'b0, K};
         OP_SUBK: wide = {1'b0, b} - {1'b0, K};
         default: wide = 9'd0;
      endcase
   end

   assign result = wide[7:0];
   assign flag   = wide[8];

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin arbiter sequencing two requesters onto one shared ALU
module alu_share_arb
   import alu_ctrl_pkg::*;
#(
   parameter logic [7:0] CONST_K = alu_ctrl_pkg::CONST_K
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [3:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   output logic [1:0]  resp_valid,
   input  logic [1:0]  resp_ready,
   output logic [7:0]  resp_data,
   output logic        resp_flag,
   output logic        busy,
   output logic [15:0] op_count
);

   localparam int NREQ = 2;

   state_t            state;
   logic              last;
   logic              gnt_q;
   logic              gnt_idx;
   logic              accept;
   logic              resp_done;
   logic [1:0]        op_q;
   logic [7:0]        a_q;
   logic [7:0]        b_q;
   logic [7:0]        data_q;
   logic              flag_q;
   logic [15:0]       op_count_q;
   logic [7:0]        alu_result;
   logic              alu_flag;
   logic [NREQ-1:0]   gnt_onehot;

   // On a tie the requester that did not win last time is served
   always_comb begin
      gnt_idx = req_valid[1];
      if (req_valid == 2'b11) begin
         gnt_idx = ~last;
      end
   end

   assign accept     = (state == IDLE) && (|req_valid);
   assign gnt_onehot = idx_onehot(gnt_q);
   assign resp_done  = (state == RESP) && resp_ready[gnt_q];

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready = idx_onehot(gnt_idx);
      end
   end

   alu8_unit #(
      .K(CONST_K)
   ) u_alu (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_result),
      .flag   (alu_flag)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last       <= 1'b1;
         gnt_q      <= 1'b0;
         op_q       <= 2'b00;
         a_q        <= 8'h00;
         b_q        <= 8'h00;
         data_q     <= 8'h00;
         flag_q     <= 1'b0;
         op_count_q <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  gnt_q <= gnt_idx;
                  op_q  <= req_op[2*gnt_idx +: 2];
                  a_q   <= req_a[8*gnt_idx +: 8];
                  b_q   <= req_b[8*gnt_idx +: 8];
                  state <= EXEC;
               end
            end
            EXEC: begin
               data_q <= alu_result;
               flag_q <= alu_flag;
               state  <= RESP;
            end
            RESP: begin
               if (resp_done) begin
                  last       <= gnt_q;
                  op_count_q <= op_count_q + 16'd1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign resp_valid = (state == RESP) ? gnt_onehot : '0;
   assign resp_data  = data_q;
   assign resp_flag  = flag_q;
   assign busy       = (state != IDLE);
   assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed-vector bench for alu_share_arb
module tb_alu_share_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_op;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready;
   logic [7:0]  resp_data;
   logic        resp_flag;
   logic        busy;
   logic [15:0] op_count;

   int n_vec  = 0;
   int n_miss = 0;

   alu_share_arb dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_flag  (resp_flag),
      .busy       (busy),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".req_ready"},  {30'd0, req_ready},  32'd0);
      check({tag, ".resp_valid"}, {30'd0, resp_valid}, 32'd0);
      check({tag, ".resp_data"},  {24'd0, resp_data},  32'd0);
      check({tag, ".resp_flag"},  {31'd0, resp_flag},  32'd0);
      check({tag, ".busy"},       {31'd0, busy},       32'd0);
      check({tag, ".op_count"},   {16'd0, op_count},   32'd0);
   endtask

   task automatic idle_inputs();
      req_valid  = 2'b00;
      req_op     = 4'h0;
      req_a      = 16'h0000;
      req_b      = 16'h0000;
      resp_ready = 2'b00;
   endtask

   task automatic load_req(input int r, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      req_op[2*r +: 2] = op;
      req_a[8*r +: 8]  = a;
      req_b[8*r +: 8]  = b;
   endtask

   // One request from requester r, checked through EXEC, RESP and back to IDLE
   task automatic run_single(input string tag, input int r, input logic [1:0] op,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] exp_data, input logic exp_flag,
                             input logic [15:0] exp_count);
      logic [1:0] oh;
      oh = (r == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      idle_inputs();
      load_req(r, op, a, b);
      req_valid = oh;
      #1;
      check({tag, ".req_ready"}, {30'd0, req_ready}, {30'd0, oh});
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      check({tag, ".exec_busy"}, {31'd0, busy}, 32'd1);
      check({tag, ".exec_rvalid"}, {30'd0, resp_valid}, 32'd0);
      @(negedge clk);
      check({tag, ".resp_valid"}, {30'd0, resp_valid}, {30'd0, oh});
      check({tag, ".resp_data"}, {24'd0, resp_data}, {24'd0, exp_data});
      check({tag, ".resp_flag"}, {31'd0, resp_flag}, {31'd0, exp_flag});
      resp_ready = oh;
      @(negedge clk);
      resp_ready = 2'b00;
      check({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
      check({tag, ".op_count"}, {16'd0, op_count}, {16'd0, exp_count});
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      run_single("r0_add",     0, 2'b00, 8'h10, 8'h20, 8'h30, 1'b0, 16'd1);
      run_single("r0_add_cy",  0, 2'b00, 8'hF0, 8'h20, 8'h10, 1'b1, 16'd2);
      run_single("r1_sub_bw",  1, 2'b01, 8'h05, 8'h07, 8'hFE, 1'b1, 16'd3);
      run_single("r1_subk_eq", 1, 2'b11, 8'h00, 8'hAA, 8'h00, 1'b0, 16'd4);

      // Continuous tie with resp_ready tied high: grants alternate 0,1,0,1
      do_reset();
      @(negedge clk);
      load_req(0, 2'b10, 8'h60, 8'h00);
      load_req(1, 2'b10, 8'h01, 8'h00);
      req_valid  = 2'b11;
      resp_ready = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("rr%0d.req_ready", k), {30'd0, req_ready},
               (k % 2 == 0) ? 32'd1 : 32'd2);
         @(negedge clk);
         @(negedge clk);
         check($sformatf("rr%0d.resp_valid", k), {30'd0, resp_valid},
               (k % 2 == 0) ? 32'd1 : 32'd2);
         check($sformatf("rr%0d.resp_data", k), {24'd0, resp_data},
               (k % 2 == 0) ? 32'h0A : 32'hAB);
         check($sformatf("rr%0d.resp_flag", k), {31'd0, resp_flag},
               (k % 2 == 0) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      check("rr.op_count", {16'd0, op_count}, 32'd4);
      idle_inputs();

      // Response backpressure for 5 cycles while both requesters wait
      @(negedge clk);
      load_req(0, 2'b00, 8'h01, 8'h02);
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      load_req(1, 2'b00, 8'h07, 8'h07);
      req_valid = 2'b11;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("bp%0d.resp_valid", k), {30'd0, resp_valid}, 32'd1);
         check($sformatf("bp%0d.resp_data", k), {24'd0, resp_data}, 32'h03);
         check($sformatf("bp%0d.req_ready", k), {30'd0, req_ready}, 32'd0);
         check($sformatf("bp%0d.busy", k), {31'd0, busy}, 32'd1);
         @(negedge clk);
      end
      resp_ready = 2'b10;
      @(negedge clk);
      check("bp.ignore_other", {30'd0, resp_valid}, 32'd1);
      resp_ready = 2'b01;
      @(negedge clk);
      check("bp.idle_busy", {31'd0, busy}, 32'd0);
      check("bp.idle_rvalid", {30'd0, resp_valid}, 32'd0);
      check("bp.rr_next", {30'd0, req_ready}, 32'd2);
      check("bp.op_count", {16'd0, op_count}, 32'd5);
      idle_inputs();

      // Reset during RESP drops the transaction
      @(negedge clk);
      load_req(1, 2'b00, 8'h02, 8'h03);
      req_valid = 2'b10;
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      check("rstmid.resp_valid", {30'd0, resp_valid}, 32'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("rstmid");
      @(negedge clk);
      check("rstmid.no_resp", {30'd0, resp_valid}, 32'd0);
      load_req(0, 2'b00, 8'h10, 8'h01);
      load_req(1, 2'b00, 8'h20, 8'h01);
      req_valid = 2'b11;
      #1;
      check("rstmid.tie_r0", {30'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      check("rstmid.data", {24'd0, resp_data}, 32'h11);
      resp_ready = 2'b01;
      @(negedge clk);
      resp_ready = 2'b00;
      check("rstmid.op_count", {16'd0, op_count}, 32'd1);

      // Counter wrap from 0xFFFF
      @(negedge clk);
      force dut.op_count_q = 16'hFFFF;
      #1;
      release dut.op_count_q;
      run_single("wrap", 0, 2'b00, 8'h01, 8'h01, 8'h02, 1'b0, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that shares one 8-bit, two-operand ALU between two requesters. It accepts one operation at a time over a valid/ready request handshake, holds the operands in registers, and evaluates the ALU for one cycle. It then returns the result and carry/borrow flag to the granted requester over a valid/ready response handshake. It sits between the requester front-ends and the shared arithmetic resource, and is the only path into that resource.

## Interface
- NREQ, 2, number of requesters; fixed at 2, not overridable.
- CONST_K, 8'hAA, immediate operand used by ops 10 and 11.
- clk  in  1  clock, all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  2  per-requester request valid, bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_op  in  4  opcode for requester i at [2i+1:2i].
- req_a  in  16  operand A for requester i at [8i+7:8i].
- req_b  in  16  operand B for requester i at [8i+7:8i].
- resp_valid  out  2  one-hot response valid to the granted requester.
- resp_ready  in  2  per-requester response accept.
- resp_data  out  8  result, shared by both requesters, qualified by resp_valid.
- resp_flag  out  1  carry (ops 00, 10) or borrow (ops 01, 11).
- busy  out  1  high in any state other than IDLE.
- op_count  out  16  completed-response counter; wraps at 0xFFFF→0x0000.

## Operation
- FSM states: IDLE → EXEC → RESP → IDLE.
- **IDLE**
  - req_ready is driven combinationally.
  - If exactly one req_valid is high, that requester is granted.
  - If both are high, the requester not granted last time is granted (round-robin pointer `last`).
  - Only the granted bit of req_ready is high.
  - On handshake: latch op, a, b and the grant index; go to EXEC.
  - With no request, stay in IDLE and keep req_ready=0.
- **EXEC**
  - The ALU evaluates the latched operands; result and flag are registered at the end of the cycle.
  - Go to RESP.
  - req_ready=0.
- **RESP**
  - resp_valid[grant]=1; resp_data and resp_flag are held stable.
  - On resp_ready[grant]: go to IDLE, set `last`=grant, increment op_count.
  - resp_ready on the non-granted bit is ignored.
  - Stalls indefinitely while resp_ready[grant]=0.
- **ALU** (9-bit internal arithmetic; data = bits [7:0], flag = bit 8):
  - op 00: a+b
  - op 01: a−b (flag=1 iff a<b)
  - op 10: a+CONST_K
  - op 11: b−CONST_K (flag=1 iff b<CONST_K)
- req_valid is not required to stay stable before grant; requesters may withdraw while not granted.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_data=0, resp_flag=0, busy=0, op_count=0, state=IDLE, `last`=1 (so requester 0 wins the first tie).
- Latency: handshake in cycle n; EXEC in cycle n+1; resp_valid high in cycle n+2.
- Minimum period is 3 cycles per operation with resp_ready tied high.
- Next accept is at the earliest in cycle n+3, which is the IDLE cycle after the response handshake.
- No request is accepted during EXEC or RESP; there is no queuing.
- Simultaneous request from both requesters in IDLE: the grant follows `last`. The loser keeps req_valid high and is granted in the next IDLE cycle.
- rst asserted mid-operation (EXEC or RESP):
  - the transaction is dropped and no response is produced;
  - all outputs return to their reset values on the next edge;
  - op_count clears.
- resp_data and resp_flag hold their last value while in IDLE and EXEC.

## Structure
- Package `alu_ctrl_pkg` holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_ADDK=2'b10, OP_SUBK=2'b11;
  - CONST_K default 8'hAA;
  - FSM state enum {IDLE, EXEC, RESP}.
- One sub-module, `alu8_unit`: combinational; inputs op, a, b; outputs result[7:0] and flag. It is instantiated once. Operand and result registers live in alu_share_arb.

## Test plan
- Requester 0 only, op 00, a=0x10, b=0x20 → resp_valid=2'b01 in cycle n+2, data=0x30, flag=0. Then a=0xF0, b=0x20 → data=0x10, flag=1.
- Requester 1 only, op 01, a=0x05, b=0x07 → resp_valid=2'b10, data=0xFE, flag=1. Op 11 with b=0xAA → data=0x00, flag=0.
- Both requesters valid continuously, op 10, a0=0x60, a1=0x01:
  - grants alternate 0,1,0,1;
  - responses 0x0A/flag 1 and 0xAB/flag 0;
  - op_count=4 after 4 responses.
- Response backpressure: resp_ready=0 for 5 cycles → resp_valid and data held constant, req_ready stays 0 throughout, busy=1. Then release → IDLE next cycle.
- rst pulsed during RESP with resp_ready=0 → no response delivered, all outputs at reset values. The next tie goes to requester 0.
- op_count preloaded by 65535 transactions (or forced) → the next response wraps op_count to 0x0000.
